// File: rtl/router_pkg.sv
// Shared router types: arbiter state codes, index-width helper, stored stream beat layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Macro USE_LIGHT_STREAM trims the stored beat to TDATA only.
package router_pkg;

   // Arbiter state codes
   typedef logic [0:0] arb_state_t;
   localparam arb_state_t ARB_IDLE   = 1'b0;
   localparam arb_state_t ARB_LOCKED = 1'b1;

   // Default stream geometry used by the input queues
   localparam int RTR_DATA_WIDTH = 32;
   localparam int RTR_ID_WIDTH   = 4;
   localparam int RTR_DEST_WIDTH = 4;

   // One stored AXI-Stream beat as held in the per-port input queue
   typedef struct packed {
      logic [RTR_DATA_WIDTH-1:0]   tdata;
`ifndef USE_LIGHT_STREAM
      logic [RTR_DATA_WIDTH/8-1:0] tstrb;
      logic [RTR_DATA_WIDTH/8-1:0] tkeep;
      logic                        tlast;
      logic [RTR_ID_WIDTH-1:0]     tid;
      logic [RTR_DEST_WIDTH-1:0]   tdest;
      logic [RTR_DEST_WIDTH-1:0]   tuser;
`endif
   } stored_axis_t;

   // Width of an index into n items; never below one bit
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: first set req after position 'last', wrapping modulo N.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the pick is consumed.
module rr_priority_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] last,
   output logic [IW-1:0] gnt_idx,
   output logic          gnt_any
);

   logic [IW-1:0] probe;

   // Walk from farthest to nearest so the nearest requester after 'last' wins
   always_comb begin
      gnt_idx = '0;
      gnt_any = 1'b0;
      probe   = '0;
      for (int k = N; k >= 1; k--) begin
         probe = IW'((int'(last) + k) % N);
         if (req[probe]) begin
            gnt_any = 1'b1;
            gnt_idx = probe;
         end
      end
   end

endmodule

// File: rtl/axis_rr_arbiter.sv
// N-to-1 AXI-Stream packet arbiter, round-robin between packets, locked to one source until TLAST.
// Latency: 1 cycle input to output through a single registered stage, 1 beat/cycle throughput.
// Backpressure: only the selected input sees TREADY, equal to (!out_vld || out_rdy).
// Macros: ROUTER_ARB_PKT_CNT_EN adds pkt_count; USE_LIGHT_STREAM carries TDATA only (every beat is a packet).
module axis_rr_arbiter
   import router_pkg::*;
#(
   parameter int N_IN       = 4,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int DEST_WIDTH = 4,
   parameter int CNT_WIDTH  = 16,
   localparam int IDX_W     = idx_width(N_IN),
   localparam int STRB_W    = DATA_WIDTH / 8
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic [N_IN-1:0]                     in_vld,
   output logic [N_IN-1:0]                     in_rdy,
   input  logic [N_IN-1:0][DATA_WIDTH-1:0]     in_dat,
`ifndef USE_LIGHT_STREAM
   input  logic [N_IN-1:0][STRB_W-1:0]         in_strb,
   input  logic [N_IN-1:0][STRB_W-1:0]         in_keep,
   input  logic [N_IN-1:0]                     in_last,
   input  logic [N_IN-1:0][ID_WIDTH-1:0]       in_id,
   input  logic [N_IN-1:0][DEST_WIDTH-1:0]     in_dest,
   input  logic [N_IN-1:0][DEST_WIDTH-1:0]     in_user,
`endif
   output logic                                out_vld,
   input  logic                                out_rdy,
   output logic [DATA_WIDTH-1:0]               out_dat,
`ifndef USE_LIGHT_STREAM
   output logic [STRB_W-1:0]                   out_strb,
   output logic [STRB_W-1:0]                   out_keep,
   output logic                                out_last,
   output logic [ID_WIDTH-1:0]                 out_id,
   output logic [DEST_WIDTH-1:0]               out_dest,
   output logic [DEST_WIDTH-1:0]               out_user,
`endif
   output logic [IDX_W-1:0]                    grant_idx
`ifdef ROUTER_ARB_PKT_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]                pkt_count
`endif
);

   typedef struct packed {
      logic [DATA_WIDTH-1:0] tdata;
`ifndef USE_LIGHT_STREAM
      logic [STRB_W-1:0]     tstrb;
      logic [STRB_W-1:0]     tkeep;
      logic                  tlast;
      logic [ID_WIDTH-1:0]   tid;
      logic [DEST_WIDTH-1:0] tdest;
      logic [DEST_WIDTH-1:0] tuser;
`endif
   } pay_t;

   arb_state_t       state;
   logic [IDX_W-1:0] owner;
   logic [IDX_W-1:0] last_grant;
   logic [IDX_W-1:0] cand;
   logic             cand_any;
   logic [IDX_W-1:0] sel;
   logic             sel_vld;
   logic             sel_last;
   logic             slot_free;
   logic             xfer;
   pay_t             in_pay [N_IN];
   pay_t             pay_q;

   rr_priority_pick #(.N(N_IN), .IW(IDX_W)) u_pick (
      .req     (in_vld),
      .last    (last_grant),
      .gnt_idx (cand),
      .gnt_any (cand_any)
   );

   // Gather each input's sideband into one payload word
   always_comb begin
      for (int i = 0; i < N_IN; i++) begin
         in_pay[i].tdata = in_dat[i];
`ifndef USE_LIGHT_STREAM
         in_pay[i].tstrb = in_strb[i];
         in_pay[i].tkeep = in_keep[i];
         in_pay[i].tlast = in_last[i];
         in_pay[i].tid   = in_id[i];
         in_pay[i].tdest = in_dest[i];
         in_pay[i].tuser = in_user[i];
`endif
      end
   end

   // Output slot can take a beat when empty or draining; held shut while in reset
   assign slot_free = rst_n && (!out_vld || out_rdy);

   // Locked: only the owner is served; idle: the rotating pick is served
   always_comb begin
      sel     = (state == ARB_LOCKED) ? owner : cand;
      sel_vld = (state == ARB_LOCKED) ? in_vld[owner] : cand_any;
      in_rdy  = '0;
      if (state == ARB_LOCKED || cand_any) begin
         in_rdy[sel] = slot_free;
      end
   end

`ifdef USE_LIGHT_STREAM
   assign sel_last = 1'b1;
`else
   assign sel_last = in_last[sel];
`endif

   assign xfer      = sel_vld && slot_free;
   assign grant_idx = (state == ARB_LOCKED) ? owner : last_grant;

   // Ownership: a non-final beat locks the source, the final beat releases it and rotates priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ARB_IDLE;
         owner      <= IDX_W'(N_IN - 1);
         last_grant <= IDX_W'(N_IN - 1);
      end else if (xfer) begin
         if (sel_last) begin
            state      <= ARB_IDLE;
            last_grant <= sel;
         end else begin
            state <= ARB_LOCKED;
            owner <= sel;
         end
      end
   end

   // Output valid: set by an accepted beat, cleared once drained with nothing behind it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld <= 1'b0;
      end else if (xfer) begin
         out_vld <= 1'b1;
      end else if (out_rdy) begin
         out_vld <= 1'b0;
      end
   end

   // Output payload: captured only on an accepted beat, so it holds while stalled
   always_ff @(posedge clk) begin
      if (xfer) begin
         pay_q <= in_pay[sel];
      end
   end

   assign out_dat  = pay_q.tdata;
`ifndef USE_LIGHT_STREAM
   assign out_strb = pay_q.tstrb;
   assign out_keep = pay_q.tkeep;
   assign out_last = pay_q.tlast;
   assign out_id   = pay_q.tid;
   assign out_dest = pay_q.tdest;
   assign out_user = pay_q.tuser;
`endif

`ifdef ROUTER_ARB_PKT_CNT_EN
   logic out_eop;
`ifdef USE_LIGHT_STREAM
   assign out_eop = 1'b1;
`else
   assign out_eop = pay_q.tlast;
`endif

   // Count packets as their final beat leaves; wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_count <= '0;
      end else if (out_vld && out_rdy && out_eop) begin
         pkt_count <= pkt_count + CNT_WIDTH'(1);
      end
   end
`endif

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Bench for axis_rr_arbiter: per-input beat queues drive the streams, a packet-level model checks every cycle.
// Latency: model expects output one cycle after each accepted input beat.
// Backpressure: out_rdy is driven directly by the directed tests.
module tb_axis_rr_arbiter;

   localparam int N   = 4;
   localparam int DW  = 32;
   localparam int IDW = 4;
   localparam int DSW = 4;
   localparam int CW  = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]          in_vld;
   logic [N-1:0]          in_rdy;
   logic [N-1:0][DW-1:0]  in_dat;
   logic [N-1:0][3:0]     in_strb;
   logic [N-1:0][3:0]     in_keep;
   logic [N-1:0]          in_last;
   logic [N-1:0][IDW-1:0] in_id;
   logic [N-1:0][DSW-1:0] in_dest;
   logic [N-1:0][DSW-1:0] in_user;
   logic                  out_vld;
   logic                  out_rdy;
   logic [DW-1:0]         out_dat;
   logic [3:0]            out_strb;
   logic [3:0]            out_keep;
   logic                  out_last;
   logic [IDW-1:0]        out_id;
   logic [DSW-1:0]        out_dest;
   logic [DSW-1:0]        out_user;
   logic [1:0]            grant_idx;
`ifdef ROUTER_ARB_PKT_CNT_EN
   logic [CW-1:0]         pkt_count;
`endif

   axis_rr_arbiter #(
      .N_IN(N), .DATA_WIDTH(DW), .ID_WIDTH(IDW), .DEST_WIDTH(DSW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
      .in_strb(in_strb), .in_keep(in_keep), .in_last(in_last),
      .in_id(in_id), .in_dest(in_dest), .in_user(in_user),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
      .out_strb(out_strb), .out_keep(out_keep), .out_last(out_last),
      .out_id(out_id), .out_dest(out_dest), .out_user(out_user),
      .grant_idx(grant_idx)
`ifdef ROUTER_ARB_PKT_CNT_EN
      , .pkt_count(pkt_count)
`endif
   );

   typedef struct {
      logic [31:0] dat;
      logic        last;
      int          gap;
   } beat_t;

   beat_t       q [N][$];
   int          waited [N];
   logic [N-1:0] acc_q = '0;
   int          hs_cnt [N];
   logic [31:0] log_dat [$];
   int          log_cyc [$];
   int          cyc = 0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic push(input int i, input logic [31:0] d, input logic l, input int g);
      beat_t b;
      b.dat  = d;
      b.last = l;
      b.gap  = g;
      q[i].push_back(b);
   endtask

   // Source drivers: pop accepted beats, present the next one after its idle gap
   initial begin
      in_vld = '0; in_dat = '0; in_last = '0;
      in_strb = '0; in_keep = '0; in_id = '0; in_dest = '0; in_user = '0;
      for (int i = 0; i < N; i++) waited[i] = 0;
      forever begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (!rst_n) begin
               q[i].delete();
               waited[i] = 0;
            end else if (acc_q[i]) begin
               void'(q[i].pop_front());
               waited[i] = 0;
            end
            if (q[i].size() > 0 && waited[i] >= q[i][0].gap) begin
               in_vld[i]  = 1'b1;
               in_dat[i]  = q[i][0].dat;
               in_last[i] = q[i][0].last;
            end else begin
               in_vld[i] = 1'b0;
               if (q[i].size() > 0) waited[i]++;
            end
            in_strb[i] = in_dat[i][3:0];
            in_keep[i] = in_dat[i][7:4];
            in_dest[i] = in_dat[i][11:8];
            in_user[i] = in_dat[i][15:12];
            in_id[i]   = IDW'(i);
         end
      end
   end

   // Packet-level reference: one output register, an owner while a packet is open,
   // otherwise the first valid input after the previous winner
   int          m_owner = -1;
   int          m_lg    = N - 1;
   logic        m_vld   = 1'b0;
   logic [31:0] m_dat;
   logic [3:0]  m_strb, m_keep, m_id, m_dest, m_user;
   logic        m_last;
   int          m_cnt   = 0;

   initial begin
      int          sel;
      logic        free;
      logic [N-1:0] exp_rdy;
      forever begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            m_owner = -1; m_lg = N - 1; m_vld = 1'b0; m_cnt = 0;
            acc_q = '0;
            chk("rst_out_vld", out_vld, 0);
            chk("rst_in_rdy", in_rdy, 0);
            chk("rst_grant", grant_idx, N - 1);
`ifdef ROUTER_ARB_PKT_CNT_EN
            chk("rst_pkt_count", pkt_count, 0);
`endif
         end else begin
            chk("out_vld", out_vld, m_vld);
            if (m_vld) begin
               chk("out_dat", out_dat, m_dat);
               chk("out_last", out_last, m_last);
               chk("out_side", {out_strb, out_keep, out_id, out_dest, out_user},
                   {m_strb, m_keep, m_id, m_dest, m_user});
            end
            chk("grant_idx", grant_idx, (m_owner >= 0) ? m_owner : m_lg);
`ifdef ROUTER_ARB_PKT_CNT_EN
            chk("pkt_count", pkt_count, m_cnt);
`endif
            free = !m_vld || out_rdy;
            sel  = -1;
            if (m_owner >= 0) sel = m_owner;
            else begin
               for (int k = 1; k <= N; k++) begin
                  if (sel < 0 && in_vld[(m_lg + k) % N]) sel = (m_lg + k) % N;
               end
            end
            exp_rdy = '0;
            if (sel >= 0 && free) exp_rdy[sel] = 1'b1;
            chk("in_rdy", in_rdy, exp_rdy);

            acc_q = in_vld & in_rdy;
            for (int i = 0; i < N; i++) if (acc_q[i]) hs_cnt[i]++;
            if (out_vld && out_rdy) begin
               log_dat.push_back(out_dat);
               log_cyc.push_back(cyc);
            end

            if (m_vld && out_rdy && m_last) m_cnt = (m_cnt + 1) % (1 << CW);
            if (sel >= 0 && free && in_vld[sel]) begin
               m_vld  = 1'b1;
               m_dat  = in_dat[sel];
               m_last = in_last[sel];
               m_strb = in_strb[sel]; m_keep = in_keep[sel]; m_id = in_id[sel];
               m_dest = in_dest[sel]; m_user = in_user[sel];
               if (in_last[sel]) begin
                  m_owner = -1;
                  m_lg    = sel;
               end else begin
                  m_owner = sel;
               end
            end else if (out_rdy) begin
               m_vld = 1'b0;
            end
         end
      end
   end

   task automatic do_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      log_dat.delete();
      log_cyc.delete();
      for (int i = 0; i < N; i++) hs_cnt[i] = 0;
   endtask

   task automatic wait_log(input string name, input int n, input int budget);
      int c;
      c = 0;
      while (log_dat.size() < n && c < budget) begin
         @(negedge clk);
         #1;
         c++;
      end
      if (log_dat.size() < n) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: timed out after %0d cycles with %0d of %0d beats", name, c, log_dat.size(), n);
      end
   endtask

   task automatic chk_log(input string name, input int base, input logic [31:0] exp [], input int n);
      for (int k = 0; k < n; k++) begin
         if (log_dat.size() > base + k) chk(name, log_dat[base + k], exp[k]);
         else chk(name, 64'hDEAD_0000, exp[k]);
      end
   endtask

   initial begin
      logic [31:0] e2 [] = '{32'h100, 32'h101, 32'h110, 32'h111, 32'h120, 32'h121, 32'h130, 32'h131};
      logic [31:0] e3 [] = '{32'hB0, 32'hB1, 32'hB2, 32'hC0};
      logic [31:0] e4 [] = '{32'hD0, 32'hD1, 32'hD2, 32'hD3};
      logic [31:0] e5 [] = '{32'hE0, 32'hE1, 32'hE2, 32'hF0};
      int c;
      int bubbles;
      out_rdy = 1'b1;

      // Reset state pinned to literals
      @(negedge clk);
      #1;
      chk("reset_out_vld", out_vld, 0);
      chk("reset_grant", grant_idx, 3);
      chk("reset_in_rdy", in_rdy, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // 1: single-beat packet on input 2, appears one cycle after acceptance
      push(2, 32'hA5, 1'b1, 0);
      c = 0;
      while (hs_cnt[2] < 1 && c < 20) begin
         @(negedge clk); #1; c++;
      end
      chk("t1_accept", hs_cnt[2], 1);
      @(negedge clk); #1;
      chk("t1_out_vld", out_vld, 1);
      chk("t1_out_dat", out_dat, 32'hA5);
      chk("t1_grant", grant_idx, 2);

      // 2: all inputs with two-beat packets -> 0,0,1,1,2,2,3,3 back to back
      do_reset();
      for (int i = 0; i < N; i++) begin
         push(i, 32'h100 + 32'(16 * i), 1'b0, 0);
         push(i, 32'h101 + 32'(16 * i), 1'b1, 0);
      end
      wait_log("t2_drain", 8, 60);
      chk_log("t2_order", 0, e2, 8);
      if (log_cyc.size() >= 8) chk("t2_no_bubble", log_cyc[7] - log_cyc[0], 7);

      // 3: input 0 arrives while input 1 is mid-packet; no interleave, granted right after TLAST
      do_reset();
      push(1, 32'hB0, 1'b0, 0);
      push(1, 32'hB1, 1'b0, 0);
      push(1, 32'hB2, 1'b1, 0);
      push(0, 32'hC0, 1'b1, 2);
      wait_log("t3_drain", 4, 60);
      chk_log("t3_order", 0, e3, 4);
      if (log_cyc.size() >= 4) chk("t3_next_cycle", log_cyc[3] - log_cyc[2], 1);

      // 4: output stall mid-packet holds payload and blocks the owner
      do_reset();
      push(2, 32'hD0, 1'b0, 0);
      push(2, 32'hD1, 1'b0, 0);
      push(2, 32'hD2, 1'b0, 0);
      push(2, 32'hD3, 1'b1, 0);
      wait_log("t4_start", 2, 40);
      @(posedge clk); #2;
      out_rdy = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk); #1;
         chk("t4_stall_vld", out_vld, 1);
         chk("t4_stall_dat", out_dat, 32'hD2);
         chk("t4_stall_rdy", in_rdy[2], 0);
      end
      @(posedge clk); #2;
      out_rdy = 1'b1;
      wait_log("t4_drain", 4, 40);
      chk_log("t4_order", 0, e4, 4);
      repeat (3) begin @(negedge clk); #1; end
      chk("t4_no_dup", hs_cnt[2], 4);
      chk("t4_log_len", log_dat.size(), 4);

      // 5: owner bubbles for 3 cycles; a waiting input must not be served
      do_reset();
      push(0, 32'hE0, 1'b0, 0);
      push(0, 32'hE1, 1'b0, 3);
      push(0, 32'hE2, 1'b1, 0);
      push(3, 32'hF0, 1'b1, 0);
      bubbles = 0;
      c = 0;
      while (log_dat.size() < 4 && c < 60) begin
         @(negedge clk); #1; c++;
         if (hs_cnt[0] < 3 && in_vld[3]) chk("t5_in3_blocked", in_rdy[3], 0);
         if (hs_cnt[0] > 0 && hs_cnt[0] < 3 && !in_vld[0]) bubbles++;
      end
      chk("t5_bubbles", bubbles, 3);
      chk_log("t5_order", 0, e5, 4);

      // 6: 17 packets, counter wraps at 16; then reset in the middle of a packet
      do_reset();
      for (int k = 0; k < 17; k++) push(1, 32'h600 + 32'(k), 1'b1, 0);
      wait_log("t6_drain", 17, 80);
      @(negedge clk); #1;
      if (log_dat.size() >= 17) chk("t6_last_beat", log_dat[16], 32'h610);
`ifdef ROUTER_ARB_PKT_CNT_EN
      chk("t6_pkt_count", pkt_count, 1);
`endif
      push(2, 32'h700, 1'b0, 0);
      push(2, 32'h701, 1'b0, 0);
      push(2, 32'h702, 1'b1, 0);
      wait_log("t6_mid", 18, 40);
      @(posedge clk); #2;
      rst_n = 1'b0;
      @(negedge clk); #1;
      chk("t6_rst_out_vld", out_vld, 0);
      chk("t6_rst_in_rdy", in_rdy, 0);
      chk("t6_rst_grant", grant_idx, 3);
`ifdef ROUTER_ARB_PKT_CNT_EN
      chk("t6_rst_pkt_count", pkt_count, 0);
`endif
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      repeat (4) begin @(negedge clk); #1; end
      chk("t6_idle_after_rst", out_vld, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      n_fail++;
      $display("FAIL watchdog: simulation did not finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog");
   end

endmodule
